// File: rtl/reg_scoreboard_decoder_if.sv
// Issue/writeback/read-port bundle for reg_scoreboard_decoder.
// The master side drives requests; the slave side (the scoreboard) returns status.
interface reg_scoreboard_decoder_if #(
   parameter int ADDR_W = 5
);
   localparam int NREG = 2**ADDR_W;

   logic              iss_valid;
   logic [ADDR_W-1:0] iss_addr;
   logic              iss_ready;
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic              hazard_a;
   logic              hazard_b;
   logic [NREG-1:0]   wr_en;
   logic [NREG-1:0]   busy;
   logic [ADDR_W:0]   busy_count;
   logic              wb_err;

   modport master (
      output iss_valid, iss_addr, wb_valid, wb_addr, rd_addr_a, rd_addr_b,
      input  iss_ready, hazard_a, hazard_b, wr_en, busy, busy_count, wb_err
   );

   modport slave (
      input  iss_valid, iss_addr, wb_valid, wb_addr, rd_addr_a, rd_addr_b,
      output iss_ready, hazard_a, hazard_b, wr_en, busy, busy_count, wb_err
   );
endinterface

// File: rtl/reg_scoreboard_decoder.sv
// Writeback decoder plus busy scoreboard for register-file write enables and issue hazards.
// Optional macro SCB_FORWARD_EN: a same-cycle writeback frees its register for issue and reads.
module reg_scoreboard_decoder #(
   parameter int ADDR_W             = 5,
   parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
   input logic                     clk,
   input logic                     rst,
   reg_scoreboard_decoder_if.slave sb
);
   localparam int              NREG      = 2**ADDR_W;
   localparam logic [NREG-1:0] ONE       = {{(NREG-1){1'b0}}, 1'b1};
   localparam logic [NREG-1:0] KEEP_MASK = ZERO_REG_HARDWIRED ? ~ONE : {NREG{1'b1}};

   function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
      logic [ADDR_W:0] c;
      c = {(ADDR_W+1){1'b0}};
      for (int k = 0; k < NREG; k++) begin
         c = c + {{ADDR_W{1'b0}}, v[k]};
      end
      return c;
   endfunction

   logic [NREG-1:0] r_wr_en;
   logic [NREG-1:0] r_busy;
   logic [ADDR_W:0] r_busy_count;
   logic            r_wb_err;

   logic [NREG-1:0] w_busy_nxt;
   logic [NREG-1:0] w_wr_en_nxt;
   logic            w_err_evt;
   logic            w_iss_zero, w_wb_zero, w_a_zero, w_b_zero;
   logic            w_fwd_iss, w_fwd_a, w_fwd_b;
   logic            w_iss_ready, w_issue, w_haz_a, w_haz_b;

   assign w_iss_zero = ZERO_REG_HARDWIRED && (sb.iss_addr  == {ADDR_W{1'b0}});
   assign w_wb_zero  = ZERO_REG_HARDWIRED && (sb.wb_addr   == {ADDR_W{1'b0}});
   assign w_a_zero   = ZERO_REG_HARDWIRED && (sb.rd_addr_a == {ADDR_W{1'b0}});
   assign w_b_zero   = ZERO_REG_HARDWIRED && (sb.rd_addr_b == {ADDR_W{1'b0}});

`ifdef SCB_FORWARD_EN
   assign w_fwd_iss = sb.wb_valid && (sb.wb_addr == sb.iss_addr);
   assign w_fwd_a   = sb.wb_valid && (sb.wb_addr == sb.rd_addr_a);
   assign w_fwd_b   = sb.wb_valid && (sb.wb_addr == sb.rd_addr_b);
`else
   assign w_fwd_iss = 1'b0;
   assign w_fwd_a   = 1'b0;
   assign w_fwd_b   = 1'b0;
`endif

   // Issue readiness and source hazards from the current scoreboard.
   always_comb begin
      w_iss_ready = 1'b1;
      w_haz_a     = 1'b0;
      w_haz_b     = 1'b0;
      if (w_iss_zero) begin
         w_iss_ready = 1'b1;
      end else begin
         w_iss_ready = !r_busy[sb.iss_addr] || w_fwd_iss;
      end
      if (w_a_zero) begin
         w_haz_a = 1'b0;
      end else begin
         w_haz_a = r_busy[sb.rd_addr_a] && !w_fwd_a;
      end
      if (w_b_zero) begin
         w_haz_b = 1'b0;
      end else begin
         w_haz_b = r_busy[sb.rd_addr_b] && !w_fwd_b;
      end
   end

   // Next scoreboard, write-enable and error event; the set is applied last so it wins.
   always_comb begin
      w_issue    = sb.iss_valid && w_iss_ready && !w_iss_zero;
      w_busy_nxt = r_busy;
      if (sb.wb_valid) begin
         w_busy_nxt = w_busy_nxt & ~(ONE << sb.wb_addr);
      end else begin
         w_busy_nxt = w_busy_nxt;
      end
      if (w_issue) begin
         w_busy_nxt = w_busy_nxt | (ONE << sb.iss_addr);
      end else begin
         w_busy_nxt = w_busy_nxt;
      end
      w_busy_nxt = w_busy_nxt & KEEP_MASK;
      if (sb.wb_valid) begin
         w_wr_en_nxt = (ONE << sb.wb_addr) & KEEP_MASK;
      end else begin
         w_wr_en_nxt = {NREG{1'b0}};
      end
      w_err_evt = sb.wb_valid && !r_busy[sb.wb_addr] && !w_wb_zero;
   end

   // State registers; reset overrides any same-cycle issue or writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_en      <= {NREG{1'b0}};
         r_busy       <= {NREG{1'b0}};
         r_busy_count <= {(ADDR_W+1){1'b0}};
         r_wb_err     <= 1'b0;
      end else begin
         r_wr_en      <= w_wr_en_nxt;
         r_busy       <= w_busy_nxt;
         r_busy_count <= popcount(w_busy_nxt);
         r_wb_err     <= r_wb_err | w_err_evt;
      end
   end

   assign sb.iss_ready  = w_iss_ready;
   assign sb.hazard_a   = w_haz_a;
   assign sb.hazard_b   = w_haz_b;
   assign sb.wr_en      = r_wr_en;
   assign sb.busy       = r_busy;
   assign sb.busy_count = r_busy_count;
   assign sb.wb_err     = r_wb_err;
endmodule

// File: tb/tb_reg_scoreboard_decoder.sv
// Directed plus randomized bench for reg_scoreboard_decoder against a set-of-pending-registers model.
module tb_reg_scoreboard_decoder;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;
   localparam bit HW     = 1'b1;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   bit              m_busy [NREG];
   logic [NREG-1:0] m_wr_en;
   bit              m_err;

   reg_scoreboard_decoder_if #(.ADDR_W(ADDR_W)) sb ();

   reg_scoreboard_decoder #(.ADDR_W(ADDR_W), .ZERO_REG_HARDWIRED(HW)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_hw_zero(input logic [ADDR_W-1:0] a);
      return HW && (a == 5'd0);
   endfunction

   function automatic bit wb_hits(input logic [ADDR_W-1:0] a);
`ifdef SCB_FORWARD_EN
      return sb.wb_valid && (sb.wb_addr == a);
`else
      return (a != a);
`endif
   endfunction

   function automatic bit model_ready(input logic [ADDR_W-1:0] a);
      return is_hw_zero(a) || !m_busy[a] || wb_hits(a);
   endfunction

   function automatic bit model_hazard(input logic [ADDR_W-1:0] a);
      return !is_hw_zero(a) && m_busy[a] && !wb_hits(a);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
      m_wr_en = 32'h0;
      m_err   = 1'b0;
   endtask

   // One clock: check combinational outputs mid-cycle, advance model, check registered outputs.
   task automatic cycle();
      bit              acc;
      logic [NREG-1:0] e_busy;
      int              cnt;
      @(negedge clk);
      chk("iss_ready", {63'd0, sb.iss_ready}, {63'd0, model_ready(sb.iss_addr)});
      chk("hazard_a", {63'd0, sb.hazard_a}, {63'd0, model_hazard(sb.rd_addr_a)});
      chk("hazard_b", {63'd0, sb.hazard_b}, {63'd0, model_hazard(sb.rd_addr_b)});
      if (rst) begin
         model_reset();
      end else begin
         acc     = sb.iss_valid && model_ready(sb.iss_addr) && !is_hw_zero(sb.iss_addr);
         m_wr_en = 32'h0;
         if (sb.wb_valid && !is_hw_zero(sb.wb_addr))
            for (int k = 0; k < NREG; k++) m_wr_en[k] = (k == int'(sb.wb_addr));
         if (sb.wb_valid && !m_busy[sb.wb_addr] && !is_hw_zero(sb.wb_addr)) m_err = 1'b1;
         if (sb.wb_valid) m_busy[sb.wb_addr] = 1'b0;
         if (acc) m_busy[sb.iss_addr] = 1'b1;
      end
      @(posedge clk);
      #1;
      cnt = 0;
      for (int k = 0; k < NREG; k++) begin
         e_busy[k] = m_busy[k];
         cnt += int'(m_busy[k]);
      end
      chk("wr_en", {32'd0, sb.wr_en}, {32'd0, m_wr_en});
      chk("busy", {32'd0, sb.busy}, {32'd0, e_busy});
      chk("busy_count", {58'd0, sb.busy_count}, 64'(cnt));
      chk("wb_err", {63'd0, sb.wb_err}, {63'd0, m_err});
   endtask

   task automatic drive(input bit iv, input int ia, input bit wv, input int wa);
      sb.iss_valid = iv;
      sb.iss_addr  = 5'(ia);
      sb.wb_valid  = wv;
      sb.wb_addr   = 5'(wa);
   endtask

   initial begin
      logic [NREG-1:0] exp_w;
      int              q[$];
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      sb.rd_addr_a = 5'd0;
      sb.rd_addr_b = 5'd0;
      drive(1'b0, 0, 1'b0, 0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      cycle();
      rst = 1'b0;

      // Reset state and idle readiness for every address
      chk("rst_busy", {32'd0, sb.busy}, 64'h0);
      chk("rst_wr_en", {32'd0, sb.wr_en}, 64'h0);
      for (int a = 0; a < NREG; a++) begin
         drive(1'b0, a, 1'b0, 0);
         cycle();
      end

      // Decode sweep: issue each register, then write it back
      for (int a = 0; a < NREG; a++) begin
         drive(1'b1, a, 1'b0, 0);
         cycle();
         drive(1'b0, 0, 1'b1, a);
         cycle();
         exp_w = (a == 0) ? 32'h0 : (32'h1 << a);
         chk("sweep_wr_en", {32'd0, sb.wr_en}, {32'd0, exp_w});
      end
      drive(1'b0, 0, 1'b0, 0);
      cycle();
      chk("sweep_wb_err", {63'd0, sb.wb_err}, 64'h0);
      chk("sweep_wr_idle", {32'd0, sb.wr_en}, 64'h0);

      // Issue and hazard on register 7
      drive(1'b1, 7, 1'b0, 0);
      cycle();
      chk("iss7_busy", {32'd0, sb.busy}, 64'h80);
      chk("iss7_count", {58'd0, sb.busy_count}, 64'd1);
      drive(1'b0, 7, 1'b0, 0);
      sb.rd_addr_a = 5'd7;
      sb.rd_addr_b = 5'd3;
      #1;
      chk("iss7_ready", {63'd0, sb.iss_ready}, 64'h0);
      chk("haz_a7", {63'd0, sb.hazard_a}, 64'h1);
      chk("haz_b3", {63'd0, sb.hazard_b}, 64'h0);
      cycle();
      drive(1'b0, 0, 1'b1, 7);
      cycle();
      chk("wb7_busy", {32'd0, sb.busy}, 64'h0);
      chk("wb7_wr_en", {32'd0, sb.wr_en}, 64'h80);

      // Simultaneous issue 5 and writeback 9
      drive(1'b1, 9, 1'b0, 0);
      cycle();
      chk("pre_sim_busy", {32'd0, sb.busy}, 64'h200);
      drive(1'b1, 5, 1'b1, 9);
      cycle();
      chk("sim_busy", {32'd0, sb.busy}, 64'h20);
      drive(1'b0, 0, 1'b1, 5);
      cycle();

      // Issue and writeback to the same busy register 12
      drive(1'b1, 12, 1'b0, 0);
      cycle();
      drive(1'b1, 12, 1'b1, 12);
      #1;
`ifdef SCB_FORWARD_EN
      chk("same12_ready", {63'd0, sb.iss_ready}, 64'h1);
`else
      chk("same12_ready", {63'd0, sb.iss_ready}, 64'h0);
`endif
      cycle();
`ifdef SCB_FORWARD_EN
      chk("same12_busy", {32'd0, sb.busy}, 64'h1000);
`else
      chk("same12_busy", {32'd0, sb.busy}, 64'h0);
`endif

      // Writeback to a free register is sticky
      drive(1'b0, 0, 1'b1, 4);
      cycle();
      chk("err_set", {63'd0, sb.wb_err}, 64'h1);
      drive(1'b0, 0, 1'b0, 0);
      repeat (3) cycle();
      chk("err_hold", {63'd0, sb.wb_err}, 64'h1);

      // Fill every register
      for (int a = 1; a < NREG; a++) begin
         drive(1'b1, a, 1'b0, 0);
         cycle();
      end
      chk("fill_count", {58'd0, sb.busy_count}, 64'd31);
      chk("fill_busy", {32'd0, sb.busy}, 64'hFFFF_FFFE);
      drive(1'b0, 0, 1'b0, 0);
      #1;
      chk("fill_r0_ready", {63'd0, sb.iss_ready}, 64'h1);

      // Reset mid-operation with both valids asserted
      rst = 1'b1;
      drive(1'b1, 3, 1'b1, 5);
      cycle();
      rst = 1'b0;
      chk("mid_rst_busy", {32'd0, sb.busy}, 64'h0);
      chk("mid_rst_count", {58'd0, sb.busy_count}, 64'h0);
      chk("mid_rst_wr_en", {32'd0, sb.wr_en}, 64'h0);
      chk("mid_rst_err", {63'd0, sb.wb_err}, 64'h0);

      // Randomized traffic, writebacks biased towards pending registers
      for (int n = 0; n < 600; n++) begin
         q.delete();
         for (int k = 0; k < NREG; k++) if (m_busy[k]) q.push_back(k);
         sb.iss_valid = 1'($urandom_range(0, 1));
         sb.iss_addr  = 5'($urandom_range(0, NREG - 1));
         sb.wb_valid  = 1'($urandom_range(0, 2) != 0);
         if (q.size() > 0 && $urandom_range(0, 7) != 0)
            sb.wb_addr = 5'(q[$urandom_range(0, q.size() - 1)]);
         else
            sb.wb_addr = 5'($urandom_range(0, NREG - 1));
         if ($urandom_range(0, 3) == 0) sb.iss_addr = sb.wb_addr;
         sb.rd_addr_a = 5'($urandom_range(0, NREG - 1));
         sb.rd_addr_b = ($urandom_range(0, 1) == 0) ? sb.wb_addr : 5'($urandom_range(0, NREG - 1));
         rst = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard_decoder.md
Name: reg_scoreboard_decoder

Overview:
- Parametrised successor to the fixed 5-to-32 one-hot decoder, used for register-file write-enable generation.
- Decodes a writeback address into a registered one-hot write-enable vector.
- Tracks pending (issued, not yet written back) destination registers in a busy scoreboard.
- Sits between issue stage and register file: stalls issue on write-after-write and flags read-after-write hazards on two source ports.

Parameters:
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers (derived, not overridable).
- ZERO_REG_HARDWIRED, 1, when 1 register 0 is never busy, never write-enabled, never hazards.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- iss_valid  input  1  issue stage presents a destination register
- iss_addr  input  ADDR_W  destination register of issuing instruction
- iss_ready  output  1  combinational; issue accepted when iss_valid && iss_ready
- wb_valid  input  1  writeback this cycle
- wb_addr  input  ADDR_W  writeback destination register
- rd_addr_a  input  ADDR_W  source register A
- rd_addr_b  input  ADDR_W  source register B
- hazard_a  output  1  combinational; source A pending
- hazard_b  output  1  combinational; source B pending
- wr_en  output  NREG  registered one-hot register-file write enable
- busy  output  NREG  registered scoreboard vector
- busy_count  output  ADDR_W+1  registered popcount of busy
- wb_err  output  1  sticky; writeback to non-busy register

Behaviour:
- Reset, synchronous on clk when rst=1: wr_en=0, busy=0, busy_count=0, wb_err=0. rst overrides all same-cycle issue and writeback, including mid-operation.
- Decode: wr_en next cycle = one-hot(wb_addr) if wb_valid, else all zeros. One-cycle latency.
- Decode bit order: bit k is set for address k, matching the original decoder's map (addr 0 -> bit 0, addr NREG-1 -> MSB).
- Register 0 with ZERO_REG_HARDWIRED=1: wr_en bit 0 is never set.
- iss_ready = !busy[iss_addr]. Register 0 is always ready when hardwired. iss_ready does not depend on iss_valid.
- Accepted issue: busy[iss_addr] is set next cycle. Accepted issue to register 0 when hardwired changes nothing.
- wb_valid: busy[wb_addr] is cleared next cycle.
- Same-cycle accepted issue and writeback to different addresses: both take effect.
- Same address: an accepted issue is impossible without the forwarding feature, because the target is busy.
- hazard_a = busy[rd_addr_a]; hazard_b = busy[rd_addr_b]. Both are forced to 0 for register 0 when hardwired.
- busy_count tracks the popcount of the next busy value, so it is always consistent with busy in the same cycle. Range 0..NREG (0..NREG-1 when hardwired).
- wb_err: set on wb_valid with busy[wb_addr]=0, excluding register 0 when hardwired. Cleared only by rst. An erroneous writeback still produces wr_en.
- No FSM beyond scoreboard state. Combinational outputs are glitch-tolerant and must be sampled only at clk.

Optional Feature:
- Macro: SCB_FORWARD_EN.
- When defined, same-cycle writeback forwarding is enabled:
  - iss_ready = !busy[iss_addr] || (wb_valid && wb_addr==iss_addr).
  - hazard_a / hazard_b are deasserted when wb_valid and wb_addr equals the source address.
  - On a simultaneous accepted issue and writeback to the same address, set wins: busy stays 1 and busy_count is unchanged.
- When not defined:
  - A writeback in the current cycle does not affect iss_ready or the hazards.
  - The register is visible as free only from the next cycle.

Test Plan:
- Reset then idle: after rst, busy=0, busy_count=0, wr_en=0, wb_err=0, iss_ready=1 for every iss_addr 0..31.
- Decode sweep: wb_valid=1 with wb_addr=0..31 on successive cycles (each register pre-issued) -> wr_en = 1<<addr one cycle later. Addr 0 gives 0 with ZERO_REG_HARDWIRED=1. wb_err stays 0.
- Issue and hazard:
  - Issue addr 7 -> busy=0x80, busy_count=1.
  - Next cycle iss_addr=7 -> iss_ready=0.
  - rd_addr_a=7 -> hazard_a=1; rd_addr_b=3 -> hazard_b=0.
  - wb 7 -> busy=0 next cycle, wr_en=0x80.
- Simultaneous events:
  - Issue 5 plus wb 9, with 9 busy -> busy goes from 0x200 to 0x20.
  - Issue 12 plus wb 12, with 12 busy: without SCB_FORWARD_EN, iss_ready=0 and busy[12] clears. With it, iss_ready=1 and busy[12] stays 1.
- Error and fill: wb to non-busy 4 -> wb_err=1, held until rst. Issue registers 1..31 -> busy_count=31, register 0 still ready.
- Reset mid-operation: busy=0xFFFFFFFE plus rst asserted with iss_valid and wb_valid -> all state 0 next cycle, no wr_en pulse.
